// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract datapath.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_adder4.sv
// 4-bit carry-lookahead slice; every carry is computed directly from generate/propagate terms.
module nibble_adder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign sum_o = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract performed one nibble per clock through a single 4-bit CLA slice,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic                 carry_q;
    logic                 ovf_q;

    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_cout;
    logic                 msb_cin;

    assign a_nib = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

    nibble_adder4 u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // Carry into the top bit, recovered from the sum bit of the final nibble.
    assign msb_cin = a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ slice_sum[NIBBLE_W-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        // Subtraction is A + ~B + 1, so B is stored inverted with carry-in forced.
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i | carry_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_NIB) begin
                        ovf_q   <= slice_cout ^ msb_cin;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sum_o       = sum_q;
    assign carry_o     = carry_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed corner cases, handshake behaviour and random ops vs. an arithmetic model.
module tb_nibble_serial_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .carry_i     (cin),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .carry_o     (cout),
        .overflow_o  (ovf),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the whole word.
    function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                      input logic rc, input logic rs,
                                      output logic [W-1:0] esum, output logic ec,
                                      output logic eo);
        logic [W:0] full;
        if (!rs) begin
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            esum = full[W-1:0];
            ec   = full[W];
            eo   = (ra[W-1] == rb[W-1]) && (esum[W-1] != ra[W-1]);
        end else begin
            esum = ra - rb;
            ec   = (ra >= rb);
            eo   = (ra[W-1] != rb[W-1]) && (esum[W-1] != ra[W-1]);
        end
    endfunction

    // Drives one operation from a negedge with in_ready high; scrambles operands after accept.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts, output logic [W-1:0] rsum, output logic rc,
                         output logic ro, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        a = ta; b = tb; cin = tc; sub = ts;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rsum = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0)
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b sum=%h c=%b ov=%b, want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] vb[5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic         vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es[5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic         ec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         eo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] rs;
        logic rc, ro;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], vs[i], rs, rc, ro, lat);
            total_cnt++;
            if (lat !== 4) $display("FAIL latency[%0d]: got %0d want 4", i, lat);
            else pass_cnt++;
            total_cnt++;
            if ({rs, rc, ro} !== {es[i], ec[i], eo[i]})
                $display("FAIL directed[%0d]: sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                         i, rs, rc, ro, es[i], ec[i], eo[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int w;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        total_cnt++;
        if (sum !== 16'h3333 || out_valid !== 1'b1)
            $display("FAIL bp_first: sum=%h vld=%b want 3333 1", sum, out_valid);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0})
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b sum=%h c=%b ov=%b want 1 0 3333 0 0",
                         i, out_valid, in_ready, sum, cout, ovf);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL bp_accept_held: busy=%b want 1", busy);
        else pass_cnt++;
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        total_cnt++;
        if (sum !== 16'h1011 || cout !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL bp_second: sum=%h c=%b vld=%b want 1011 0 1", sum, cout, out_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0)
            $display("FAIL reset_mid_run: rdy=%b vld=%b busy=%b sum=%h c=%b ov=%b, want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, cout, ovf);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_discard: activity cycles=%0d want 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, rs, es;
        logic rc, rsb, oc, oo, ec, eo;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            if (i % 5 == 0) rb = ~ra;
            rc = 1'($urandom); rsb = 1'($urandom);
            ref_model(ra, rb, rc, rsb, es, ec, eo);
            do_op(ra, rb, rc, rsb, rs, oc, oo, lat);
            total_cnt++;
            if ({rs, oc, oo} !== {es, ec, eo} || lat !== 4)
                $display("FAIL random[%0d] %h %s %h c%b: sum=%h c=%b ov=%b lat=%0d want sum=%h c=%b ov=%b lat=4",
                         i, ra, rsb ? "-" : "+", rb, rc, rs, oc, oo, lat, es, ec, eo);
            else pass_cnt++;
        end
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
